// File: rtl/interleaver_pkg.sv
// Shared constants and helpers for the CRC-24A attach stage feeding the interleaver.
// Block lengths, CRC generator, counter type and FSM state encodings live here.
package interleaver_pkg;

  localparam int K_SMALL = 1056;
  localparam int K_LARGE = 6144;
  localparam int CRC_W   = 24;
  localparam int CNT_W   = 13;

  localparam logic [CRC_W-1:0] CRC_POLY = 24'h864CFB;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef logic [CNT_W-1:0] cnt_t;

  // Code-block length (payload + parity) selected by the block_size flag.
  function automatic cnt_t k_len(input logic bs);
    return bs ? cnt_t'(K_LARGE) : cnt_t'(K_SMALL);
  endfunction

endpackage

// File: rtl/crc24_lfsr.sv
// CRC-24A register: MSB-first Galois step on payload bits, plain zero-fill shift
// to stream the remainder out, and a synchronous clear.
module crc24_lfsr
  import interleaver_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             shift_out,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_reg;
  logic [CRC_W-1:0] step_next;
  logic             fb;

  assign fb = din ^ crc_reg[CRC_W-1];

  genvar gi;
  generate
    for (gi = 0; gi < CRC_W; gi++) begin : g_step
      if (gi == 0) begin : g_lsb
        assign step_next[gi] = fb & CRC_POLY[gi];
      end else begin : g_bit
        assign step_next[gi] = crc_reg[gi-1] ^ (fb & CRC_POLY[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      crc_reg <= '0;
    end else if (en) begin
      if (shift_out) begin
        crc_reg <= {crc_reg[CRC_W-2:0], 1'b0};
      end else begin
        crc_reg <= step_next;
      end
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/crc24_attach.sv
// Streams a serial payload through to the interleaver and appends its CRC-24A,
// producing one K-bit code block framed by CRC_start / CRC_END pulses.
module crc24_attach
  import interleaver_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic il_ready,
  input  logic in_start,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_block_size,
  output logic in_ready,
  output logic crc_valid,
  output logic CRC_data,
  output logic CRC_start,
  output logic CRC_END,
  output logic block_size,
  output logic busy
);

  logic [1:0] state_reg, state_next;
  cnt_t       cnt_reg, cnt_next;
  logic       bs_reg, bs_next;

  logic       valid_reg, valid_next;
  logic       data_reg, data_next;
  logic       start_reg, start_next;
  logic       end_reg, end_next;
  logic       busy_reg, busy_next;

  logic             lfsr_clr, lfsr_en, lfsr_shift;
  logic [CRC_W-1:0] crc;

  cnt_t k_cur;
  cnt_t data_len;
  logic accept;

  assign k_cur    = k_len(bs_reg);
  assign data_len = k_cur - cnt_t'(CRC_W);
  assign in_ready = ((state_reg == ST_IDLE) && il_ready) || (state_reg == ST_DATA);
  assign accept   = in_valid && in_ready;

  crc24_lfsr u_lfsr (
    .clk       (clk),
    .clr       (reset || lfsr_clr),
    .en        (lfsr_en),
    .shift_out (lfsr_shift),
    .din       (in_bit),
    .crc       (crc)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bs_next    = bs_reg;
    lfsr_clr   = 1'b0;
    lfsr_en    = 1'b0;
    lfsr_shift = 1'b0;
    valid_next = 1'b0;
    data_next  = 1'b0;
    start_next = 1'b0;
    end_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Bits offered without in_start are consumed and dropped here.
        if (accept && in_start) begin
          bs_next    = in_block_size;
          cnt_next   = cnt_t'(1);
          lfsr_en    = 1'b1;
          valid_next = 1'b1;
          data_next  = in_bit;
          start_next = 1'b1;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          lfsr_en    = 1'b1;
          valid_next = 1'b1;
          data_next  = in_bit;
          cnt_next   = cnt_reg + cnt_t'(1);
          if (cnt_reg + cnt_t'(1) == data_len) begin
            state_next = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        // cnt == K is a tail cycle with no output, giving one idle cycle between blocks.
        if (cnt_reg == k_cur) begin
          lfsr_clr   = 1'b1;
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          lfsr_en    = 1'b1;
          lfsr_shift = 1'b1;
          valid_next = 1'b1;
          data_next  = crc[CRC_W-1];
          end_next   = (cnt_reg == k_cur - cnt_t'(1));
          cnt_next   = cnt_reg + cnt_t'(1);
        end
      end
      default: begin
        lfsr_clr   = 1'b1;
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bs_reg    <= 1'b0;
      valid_reg <= 1'b0;
      data_reg  <= 1'b0;
      start_reg <= 1'b0;
      end_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bs_reg    <= bs_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
      start_reg <= start_next;
      end_reg   <= end_next;
      busy_reg  <= busy_next;
    end
  end

  assign crc_valid  = valid_reg;
  assign CRC_data   = data_reg;
  assign CRC_start  = start_reg;
  assign CRC_END    = end_reg;
  assign block_size = bs_reg;
  assign busy       = busy_reg;

endmodule
